// File: rtl/error_vector_builder.sv
// Builds the n-bit error vector from t sampled error positions into a WORDS x e_width RAM
// and serves it to the encryption stage through a 1-cycle read-only port.
module error_vector_builder #(
   parameter int parameter_set = 1,
   parameter int n = (parameter_set == 1) ? 3488 : (parameter_set == 2) ? 4608 :
                     (parameter_set == 3) ? 6688 : (parameter_set == 4) ? 6960 : 8192,
   parameter int m = (parameter_set == 1) ? 12 : 13,
   parameter int t = (parameter_set == 1) ? 64 : (parameter_set == 2) ? 96 :
                     (parameter_set == 3) ? 128 : (parameter_set == 4) ? 119 : 128,
   parameter int e_width = 160,
   parameter int WORDS = (n + e_width - 1) / e_width,
   parameter int AW = $clog2(WORDS) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               index_valid,
   input  logic [m-1:0]       index,
   output logic               index_ready,
   output logic               done,
   output logic               busy,
   output logic               dup_err,
   output logic               range_err,
   input  logic               rd_e,
   input  logic [AW-1:0]      e_addr,
   output logic [e_width-1:0] error
);

   localparam int CW = $clog2(t + 1);
   localparam logic [e_width-1:0] Msb = {1'b1, {(e_width - 1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StClear, StAccept, StDiv, StWr, StDone} state_t;

   state_t            state_q, state_d;
   logic [m-1:0]      idx_q, idx_d;
   logic [m-1:0]      rem_q, rem_d;
   logic [AW-1:0]     quo_q, quo_d;
   logic [AW-1:0]     wc_q, wc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              dup_q, dup_d;
   logic              rng_q, rng_d;

   logic [e_width-1:0] mem [WORDS];
   logic [e_width-1:0] q_a;
   logic [e_width-1:0] onehot;
   logic [e_width-1:0] wdata;
   logic [AW-2:0]      waddr;
   logic               we;
   logic               rd_a;

   assign onehot    = Msb >> rem_q;
   assign dup_err   = dup_q;
   assign range_err = rng_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      wc_d        = wc_q;
      cnt_d       = cnt_q;
      dup_d       = dup_q;
      rng_d       = rng_q;
      we          = 1'b0;
      waddr       = wc_q[AW-2:0];
      wdata       = '0;
      rd_a        = 1'b0;
      index_ready = 1'b0;
      done        = 1'b0;
      busy        = (state_q != StIdle) && (state_q != StDone);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StClear;
               dup_d   = 1'b0;
               rng_d   = 1'b0;
               wc_d    = '0;
               cnt_d   = '0;
            end
         end
         StClear: begin
            we    = 1'b1;
            wc_d  = wc_q + 1'b1;
            if (wc_q == AW'(WORDS - 1)) state_d = StAccept;
         end
         StAccept: begin
            index_ready = 1'b1;
            if (index_valid) begin
               idx_d   = index;
               rem_d   = index;
               quo_d   = '0;
               cnt_d   = cnt_q + 1'b1;
               state_d = StDiv;
            end
         end
         StDiv: begin
            if ({1'b0, idx_q} >= (m + 1)'(n)) begin
               rng_d   = 1'b1;
               state_d = (cnt_q == CW'(t)) ? StDone : StAccept;
            end else if (rem_q >= m'(e_width)) begin
               rem_d = rem_q - m'(e_width);
               quo_d = quo_q + 1'b1;
            end else begin
               // Port A read is launched on the DIV exit edge so WR sees the word next cycle.
               rd_a    = 1'b1;
               state_d = StWr;
            end
         end
         StWr: begin
            we    = 1'b1;
            waddr = quo_q[AW-2:0];
            wdata = q_a | onehot;
            if (|(q_a & onehot)) dup_d = 1'b1;
            state_d = (cnt_q == CW'(t)) ? StDone : StAccept;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         wc_q    <= '0;
         cnt_q   <= '0;
         dup_q   <= 1'b0;
         rng_q   <= 1'b0;
         error   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         wc_q    <= wc_d;
         cnt_q   <= cnt_d;
         dup_q   <= dup_d;
         rng_q   <= rng_d;
         if (rd_e) error <= (e_addr < AW'(WORDS)) ? mem[e_addr[AW-2:0]] : '0;
      end
   end

   // RAM contents survive reset; the next start clears them.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rd_a) q_a <= mem[quo_q[AW-2:0]];
   end

endmodule

// File: tb/tb_error_vector_builder.sv
// Directed bench for error_vector_builder, parameter set 1.
module tb_error_vector_builder;

   localparam int EW = 160;
   localparam int NW = 22;
   localparam int AW = 6;
   localparam int M  = 12;
   localparam int N  = 3488;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          index_valid;
   logic [M-1:0]  index;
   logic          index_ready;
   logic          done;
   logic          busy;
   logic          dup_err;
   logic          range_err;
   logic          rd_e;
   logic [AW-1:0] e_addr;
   logic [EW-1:0] error;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;

   int            vec[$];
   logic [EW-1:0] expw [NW];
   logic [EW-1:0] gotw [NW];

   error_vector_builder #(.parameter_set(1)) dut (
      .clk(clk), .rst(rst), .start(start), .index_valid(index_valid), .index(index),
      .index_ready(index_ready), .done(done), .busy(busy), .dup_err(dup_err),
      .range_err(range_err), .rd_e(rd_e), .e_addr(e_addr), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int c);
      int k = 0;
      while (!index_ready && k < 100) begin
         step();
         k++;
      end
      if (!index_ready) check("ready_timeout", index_ready, 1);
      c = cyc;
   endtask

   task automatic send(input int v, output int t0);
      int c;
      wait_ready(c);
      index_valid = 1'b1;
      index = M'(v);
      t0 = cyc;
      step();
      index_valid = 1'b0;
   endtask

   task automatic read_word(input int a);
      rd_e = 1'b1;
      e_addr = AW'(a);
      step();
      rd_e = 1'b0;
   endtask

   // Runs one full vector from vec and checks timing, flags and the readout.
   task automatic run_vec(input string tag, input int exp_pop, input logic exp_dup,
                          input logic exp_rng);
      int s, c, t0, d0, k, pop, gap;
      d0 = done_cnt;
      s = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_ready(c);
      check({tag, "_clear_lat"}, c - s, 23);
      foreach (vec[i]) begin
         if (i > 0) begin
            wait_ready(c);
            gap = vec[i-1] / EW + 3;
            if (vec[i-1] < N) check({tag, "_gap"}, c - t0, gap);
         end
         send(vec[i], t0);
      end
      k = 0;
      while (done_cnt == d0 && k < 100) begin
         step();
         k++;
      end
      repeat (5) step();
      check({tag, "_done_once"}, done_cnt - d0, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_dup"}, dup_err, exp_dup);
      check({tag, "_rng"}, range_err, exp_rng);
      for (int w = 0; w < NW; w++) expw[w] = '0;
      foreach (vec[i]) if (vec[i] < N) expw[vec[i] / EW][EW - 1 - vec[i] % EW] = 1'b1;
      pop = 0;
      for (int a = 0; a < NW; a++) begin
         read_word(a);
         gotw[a] = error;
         pop += $countones(error);
         check({tag, "_word"}, gotw[a], expw[a]);
      end
      check({tag, "_pop"}, pop, exp_pop);
   endtask

   initial begin
      int t0;
      rst = 1'b1;
      start = 1'b0;
      index_valid = 1'b0;
      index = '0;
      rd_e = 1'b0;
      e_addr = '0;
      #12;
      check("rst_ready", index_ready, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", {dup_err, range_err}, 0);
      check("rst_error", error, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step();

      // Boundary indices plus 60 distinct fillers.
      vec = {0, 159, 160, 3487};
      for (int k = 0; k < 60; k++) vec.push_back(200 + 37 * k);
      run_vec("v1", 64, 1'b0, 1'b0);
      check("v1_w0_b159", gotw[0][159], 1);
      check("v1_w0_b0", gotw[0][0], 1);
      check("v1_w1_b159", gotw[1][159], 1);
      check("v1_w21_b32", gotw[21][32], 1);

      // Duplicate index 5.
      vec = {5, 5};
      for (int k = 0; k < 62; k++) vec.push_back(300 + 11 * k);
      run_vec("dup", 63, 1'b1, 1'b0);

      // Out-of-range index 4000.
      vec = {4000};
      for (int k = 0; k < 63; k++) vec.push_back(1000 + 13 * k);
      run_vec("rng", 63, 1'b0, 1'b1);

      read_word(6);
      check("pre_rst_word6", error, expw[6]);

      // Asynchronous reset while dividing a large index.
      start = 1'b1;
      step();
      start = 1'b0;
      send(3000, t0);
      repeat (5) step();
      check("mid_div_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_ready", index_ready, 0);
      check("arst_error", error, 0);
      check("arst_flags", {dup_err, range_err, done}, 0);
      repeat (2) step();
      rst = 1'b0;
      step();

      vec = {};
      for (int k = 0; k < 64; k++) vec.push_back(2 + 41 * k);
      run_vec("clean", 64, 1'b0, 1'b0);
      read_word(0);
      check("clean_word0", error, expw[0]);
      read_word(22);
      check("addr22_zero", error, 0);
      rd_e = 1'b0;
      e_addr = 6'd3;
      step();
      check("rd_hold", error, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
